// File: rtl/noc_route_pkg.sv
// Shared types for the route-select generator: flit layout, default field widths, FSM states.
package noc_route_pkg;

    localparam int DEST_W_DEF = 4;
    localparam int LEN_W_DEF  = 4;

    typedef struct packed {
        logic                  tail;
        logic [DEST_W_DEF-1:0] dest;
        logic [LEN_W_DEF-1:0]  len;
    } flit_t;

    typedef enum logic {
        HEAD = 1'b0,
        BODY = 1'b1
    } route_state_e;

endpackage

// File: rtl/route_sel_gen_if.sv
// Flit stream bundle: upstream flits in, (flit, select) pairs out to the leaf decoder.
interface route_sel_gen_if #(
    parameter int W = 9
);
    logic [W-1:0] in_data;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] out_data;
    logic         out_sel;
    logic         out_valid;
    logic         out_ready;

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_sel, out_valid
    );

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_sel, out_valid
    );
endinterface

// File: rtl/route_skid_buf.sv
// Two-entry valid/ready buffer with fully registered outputs, including the ready back to upstream.
module route_skid_buf #(
    parameter int P = 10
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic [P-1:0] i_data,
    input  logic         i_valid,
    output logic         o_ready,
    output logic [P-1:0] o_data,
    output logic         o_valid,
    input  logic         i_ready
);

    logic [P-1:0] r_head;
    logic [P-1:0] r_spare;
    logic [1:0]   r_count;
    logic         r_ready;
    logic         r_valid;

    logic         w_push;
    logic         w_pop;
    logic [P-1:0] w_head_n;
    logic [P-1:0] w_spare_n;
    logic [1:0]   w_count_n;

    assign w_push = i_valid && r_ready;
    assign w_pop  = r_valid && i_ready;

    // The head entry always drives the output; the spare only fills while the head is stalled.
    always_comb begin
        w_head_n  = r_head;
        w_spare_n = r_spare;
        w_count_n = r_count;
        case (r_count)
            2'd0: begin
                if (w_push) begin
                    w_head_n  = i_data;
                    w_count_n = 2'd1;
                end
            end
            2'd1: begin
                if (w_push && w_pop) begin
                    w_head_n = i_data;
                end else if (w_push) begin
                    w_spare_n = i_data;
                    w_count_n = 2'd2;
                end else if (w_pop) begin
                    w_count_n = 2'd0;
                end
            end
            default: begin
                if (w_pop) begin
                    w_head_n  = r_spare;
                    w_count_n = 2'd1;
                end
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_head  <= '0;
            r_spare <= '0;
            r_count <= 2'd0;
            r_ready <= 1'b1;
            r_valid <= 1'b0;
        end else begin
            r_head  <= w_head_n;
            r_spare <= w_spare_n;
            r_count <= w_count_n;
            r_ready <= (w_count_n != 2'd2);
            r_valid <= (w_count_n != 2'd0);
        end
    end

    assign o_ready = r_ready;
    assign o_data  = r_head;
    assign o_valid = r_valid;

endmodule

// File: rtl/route_sel_gen.sv
// Route-select generator: tags every flit of a packet with the header's dest[LEVEL] bit.
// Optional ROUTE_LEN_CHECK_EN adds a sticky len_err framing check against the header length.
module route_sel_gen
    import noc_route_pkg::*;
#(
    parameter int DEST_W = DEST_W_DEF,
    parameter int LEN_W  = LEN_W_DEF,
    parameter int LEVEL  = 0
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    route_sel_gen_if.slave  bus
`ifdef ROUTE_LEN_CHECK_EN
    ,
    output logic            o_len_err
`endif
);

    localparam int W = 1 + DEST_W + LEN_W;

    route_state_e r_state;
    logic         r_route;

    logic         w_in_ready;
    logic         w_push;
    logic         w_tail;
    logic         w_dest_bit;
    logic         w_sel_now;
    logic [W:0]   w_out_pkt;

    assign w_push     = bus.in_valid && w_in_ready;
    assign w_tail     = bus.in_data[W-1];
    assign w_dest_bit = bus.in_data[LEN_W+LEVEL];
    assign w_sel_now  = (r_state == HEAD) ? w_dest_bit : r_route;

    // Framing follows the tail bit alone; the route bit is captured only from headers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= HEAD;
            r_route <= 1'b0;
        end else if (w_push) begin
            if (r_state == HEAD) begin
                r_route <= w_dest_bit;
            end
            r_state <= w_tail ? HEAD : BODY;
        end
    end

`ifdef ROUTE_LEN_CHECK_EN
    localparam logic [LEN_W-1:0] L_ONE = LEN_W'(1);

    logic [LEN_W-1:0] r_len_cnt;
    logic             r_len_err;
    logic [LEN_W-1:0] w_len;

    assign w_len = bus.in_data[LEN_W-1:0];

    // Counter holds the number of body flits still expected; the error only observes, never stalls.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_len_cnt <= '0;
            r_len_err <= 1'b0;
        end else if (w_push) begin
            if (r_state == HEAD) begin
                r_len_cnt <= w_len;
                if (w_tail && (w_len != '0)) begin
                    r_len_err <= 1'b1;
                end
            end else begin
                r_len_cnt <= r_len_cnt - L_ONE;
                if (w_tail ? (r_len_cnt != L_ONE) : (r_len_cnt == L_ONE)) begin
                    r_len_err <= 1'b1;
                end
            end
        end
    end

    assign o_len_err = r_len_err;
`endif

    route_skid_buf #(
        .P (W + 1)
    ) u_skid (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_data  ({w_sel_now, bus.in_data}),
        .i_valid (bus.in_valid),
        .o_ready (w_in_ready),
        .o_data  (w_out_pkt),
        .o_valid (bus.out_valid),
        .i_ready (bus.out_ready)
    );

    assign bus.in_ready = w_in_ready;
    assign bus.out_sel  = w_out_pkt[W];
    assign bus.out_data = w_out_pkt[W-1:0];

endmodule
